// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes, FSM states
// and op-decoding helpers.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } mdu_state_e;

  function automatic logic is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational radix-2 step: shift-add for multiply, restoring shift-subtract
// for divide. acc_hi is the W+1 bit accumulator / partial remainder.
module mdu_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH:0]   acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH:0]   acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum     = acc_hi_i + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_hi_i[WIDTH-1:0], acc_lo_i[WIDTH-1]};
    // Extra top bit acts as the borrow of the trial subtraction.
    diff    = {1'b0, shifted} - {2'b00, opnd_i};
    if (div_i) begin
      acc_hi_o = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
      acc_lo_o = {acc_lo_i[WIDTH-2:0], ~diff[WIDTH+1]};
    end else begin
      acc_hi_o = {1'b0, sum[WIDTH:1]};
      acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with start/busy/done handshake; results land in
// HI/LO (MIPS convention) after a fixed WIDTH+2 cycle run.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sx_q, sx_d, sy_q, sy_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic               sx_in, sy_in;
  logic [WIDTH-1:0]   x_mag, y_mag;
  logic [2*WIDTH-1:0] prod_raw, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  mdu_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_i   (is_div(op_q)),
    .acc_hi_i(acc_hi_q),
    .acc_lo_i(acc_lo_q),
    .opnd_i  (opnd_q),
    .acc_hi_o(step_hi),
    .acc_lo_o(step_lo)
  );

  always_comb begin
    sx_in = is_signed(op) & x[WIDTH-1];
    sy_in = is_signed(op) & y[WIDTH-1];
    x_mag = sx_in ? -x : x;
    y_mag = sy_in ? -y : y;
  end

  // Sign correction and divide-by-zero override, applied once the iterations finish.
  always_comb begin
    prod_raw = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    prod     = (sx_q ^ sy_q) ? -prod_raw : prod_raw;
    quo      = (sx_q ^ sy_q) ? -acc_lo_q : acc_lo_q;
    rem      = sx_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
    if (!is_div(op_q)) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else if (opnd_q == '0) begin
      fix_hi = x_q;
      fix_lo = '1;
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    x_d      = x_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          op_d     = op;
          sx_d     = sx_in;
          sy_d     = sy_in;
          x_d      = x;
          acc_hi_d = '0;
          acc_lo_d = x_mag;
          opnd_d   = y_mag;
          cnt_d    = CntW'(WIDTH - 1);
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          if (cnt_q == '0) begin
            state_d = StFixup;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StFixup: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      x_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      x_q      <= x_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq (WIDTH=32): directed vectors, random ops against a
// 64-bit reference model, and handshake/abort/reset corner cases.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int unsigned Width = 32;
  localparam int          DoneAt = 34;  // negedges after the accepting edge

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  mdu_seq #(
    .WIDTH(Width)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .x    (x),
    .y    (y),
    .abort(abort),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      pa, pb, r;
    logic [63:0] u;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    if (o[1] && b == 32'd0) begin
      eh = a;
      el = '1;
    end else begin
      case (o)
        MDU_MULT:  begin r = pa * pb; u = r; eh = u[63:32]; el = u[31:0]; end
        MDU_MULTU: begin u = {32'd0, a} * {32'd0, b}; eh = u[63:32]; el = u[31:0]; end
        MDU_DIV:   begin
          r = pa / pb; u = r; el = u[31:0];
          r = pa % pb; u = r; eh = u[31:0];
        end
        default:   begin el = a / b; eh = a % b; end
      endcase
    end
  endfunction

  // Issue one op, check latency/result from the scoreboard, then poke start in DONE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    int   n;
    exp_t e;
    sb.push_back('{hi: eh, lo: el});
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    @(negedge clk);
    start = 1'b0; x = $urandom; y = $urandom;
    n = 1;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && n < DoneAt + 10) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'(DoneAt));
    e = sb.pop_front();
    check_eq({tag, "_hi"}, 64'(hi), 64'(e.hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(e.lo));
    last_hi = e.hi;
    last_lo = e.lo;
    start = 1'b1; op = MDU_MULTU;
    @(negedge clk);
    check_eq({tag, "_post_busy"}, 64'({busy, done}), 64'd0);
    start = 1'b0;
  endtask

  // DIVU 100/7 with abort raised at negedge 'at'; no done and unchanged hi/lo expected.
  task automatic run_abort(input int at, input string tag);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; x = 32'd100; y = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= DoneAt + 10; n++) begin
      if (done) seen = 1'b1;
      if (n == at) abort = 1'b1;
      if (n == at + 1) begin
        abort = 1'b0;
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
      end
      @(negedge clk);
    end
    check_eq({tag, "_nodone"}, 64'(seen), 64'd0);
    check_eq({tag, "_hi"}, 64'(hi), 64'(last_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(last_lo));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, eh, el;
    logic        seen;
    int          n;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
    run_op(MDU_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, "multu");
    run_op(MDU_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, "divu");
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
    run_op(MDU_DIV,   32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "div_zero");
    run_op(MDU_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu_zero");

    for (int i = 0; i < 8; i++) begin
      ro = 2'(i);
      ra = $urandom;
      rb = (i >= 6) ? 32'($urandom_range(1, 50)) : $urandom;
      model(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, eh, el, $sformatf("rand%0d", i));
    end

    // start while busy is dropped without queueing
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; x = 32'd100; y = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < DoneAt + 10) begin
      if (n == 10) begin start = 1'b1; op = MDU_MULT; x = 32'd2; y = 32'd3; end
      if (n == 11) start = 1'b0;
      @(negedge clk);
      n++;
    end
    check_eq("busy_start_lat", 64'(n), 64'(DoneAt));
    check_eq("busy_start_hi", 64'(hi), 64'd2);
    check_eq("busy_start_lo", 64'(lo), 64'd14);
    seen = 1'b0;
    repeat (DoneAt + 6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_eq("busy_start_noqueue", 64'(seen), 64'd0);

    // refresh hi/lo to values the aborted DIVU would not produce
    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "pre_abort");
    run_abort(20, "abort_calc");
    run_abort(33, "abort_fixup");

    // abort beats start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = MDU_DIVU; x = 32'd100; y = 32'd7;
    @(negedge clk);
    check_eq("abort_idle_busy", 64'(busy), 64'd0);
    start = 1'b0; abort = 1'b0;

    // asynchronous reset mid-op
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= DoneAt + 10; k++) begin
      if (done) seen = 1'b1;
      if (k == 15) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", {busy, done, 30'd0, hi}, 64'd0);
        check_eq("rst_mid_lo", 64'(lo), 64'd0);
      end
      if (k == 16) rst_n = 1'b1;
      @(negedge clk);
    end
    check_eq("rst_mid_nodone", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
